// File: rtl/display_bcd_seq.sv
// Sequential binary-to-BCD seven-segment driver: double-dabble one bit per cycle,
// then a single registered update of all digit patterns with optional zero blanking.
//
// state | meaning
// IDLE  | ready for a new value, seg holds last result
// CONV  | shift-and-add-3, one input bit per cycle
// WRITE | encode digits into seg, pulse done
module display_bcd_seq #(
  parameter int p_in_nbits = 8,
  parameter int p_ndigits  = 3,
  parameter int p_blank    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [p_in_nbits-1:0]    in,
  output logic [7*p_ndigits-1:0]   seg,
  output logic                     done
);

  localparam int DW = 4 * p_ndigits;
  localparam int SW = 7 * p_ndigits;
  localparam int CW = $clog2(p_in_nbits) + 1;
  localparam logic [CW-1:0] LAST = CW'(p_in_nbits - 1);

  function automatic bit digits_fit(input int nbits, input int ndig);
    longint p10;
    longint p2;
    p10 = 1;
    p2  = 1;
    for (int i = 0; i < ndig; i++) p10 = p10 * 10;
    for (int i = 0; i < nbits; i++) p2 = p2 * 2;
    return p10 >= p2;
  endfunction

  generate
    if (!digits_fit(p_in_nbits, p_ndigits)) begin : g_bad_params
      $error("display_bcd_seq: p_ndigits too small for p_in_nbits");
    end
  endgenerate

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

  state_t                 state;
  logic [p_in_nbits-1:0]  shift;
  logic [DW-1:0]          bcd;
  logic [DW-1:0]          adj;
  logic [CW-1:0]          cnt;
  logic [SW-1:0]          seg_next;
  logic                   zero_hi;
  logic [3:0]             dig;

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    adj = bcd;
    for (int k = 0; k < p_ndigits; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down; a digit blanks only while everything above it is zero.
  always_comb begin
    seg_next = '1;
    zero_hi  = 1'b1;
    dig      = '0;
    for (int k = p_ndigits - 1; k >= 0; k--) begin
      dig     = bcd[4*k +: 4];
      zero_hi = zero_hi && (dig == 4'd0);
      if ((p_blank != 0) && (k != 0) && zero_hi)
        seg_next[7*k +: 7] = 7'b1111111;
      else
        seg_next[7*k +: 7] = enc(dig);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      seg    <= '1;
      done   <= 1'b0;
      in_rdy <= 1'b1;
      shift  <= '0;
      bcd    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_val && in_rdy) begin
            shift  <= in;
            bcd    <= '0;
            cnt    <= '0;
            in_rdy <= 1'b0;
            state  <= CONV;
          end
        end
        CONV: begin
          bcd   <= {adj[DW-2:0], shift[p_in_nbits-1]};
          shift <= shift << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= WRITE;
        end
        WRITE: begin
          seg    <= seg_next;
          done   <= 1'b1;
          in_rdy <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          in_rdy <= 1'b1;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_bcd_seq.sv
// Bench for display_bcd_seq: default instance plus a 5-bit/2-digit unblanked variant,
// checked against a decimal-arithmetic reference of the display contents.
module tb_display_bcd_seq;

  logic        clk;
  logic        rst;
  logic        val_a, rdy_a, done_a;
  logic [7:0]  in_a;
  logic [20:0] seg_a;
  logic        val_b, rdy_b, done_b;
  logic [4:0]  in_b;
  logic [13:0] seg_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [20:0] prev_a;
  logic [20:0] prev_b;

  display_bcd_seq #(.p_in_nbits(8), .p_ndigits(3), .p_blank(1)) dut_a (
    .clk(clk), .rst(rst), .in_val(val_a), .in_rdy(rdy_a), .in(in_a), .seg(seg_a), .done(done_a)
  );

  display_bcd_seq #(.p_in_nbits(5), .p_ndigits(2), .p_blank(0)) dut_b (
    .clk(clk), .rst(rst), .in_val(val_b), .in_rdy(rdy_b), .in(in_b), .seg(seg_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] code7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference: decimal digits by division; digit k>=1 blanks when the value is below 10^k.
  function automatic logic [20:0] exp_seg(input int v, input int nd, input bit blank);
    logic [20:0] r;
    int p;
    r = '1;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (blank && k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
      else r[7*k +: 7] = code7((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic run_a(input int v);
    int lat, low;
    bit got, hold_bad;
    logic [20:0] e;
    e = exp_seg(v, 3, 1);
    for (int i = 0; i < 20 && !rdy_a; i++) tick();
    check("a_rdy_before", {31'b0, rdy_a}, 1);
    in_a = v[7:0];
    val_a = 1'b1;
    tick();
    lat = 0; low = 0; got = 0; hold_bad = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (!rdy_a) low++;
      if (seg_a !== prev_a) hold_bad = 1;
      in_a  = 8'($urandom);
      val_a = 1'($urandom);
      tick();
      lat++;
      if (done_a) got = 1;
    end
    val_a = 1'b0;
    check("a_done_seen", {31'b0, got}, 1);
    check("a_latency", lat, 9);
    check("a_rdy_low_cycles", low, 9);
    check("a_seg_held", {31'b0, hold_bad}, 0);
    check("a_seg", {11'b0, seg_a}, {11'b0, e});
    check("a_rdy_at_done", {31'b0, rdy_a}, 1);
    tick();
    check("a_done_one_cycle", {31'b0, done_a}, 0);
    prev_a = e;
  endtask

  task automatic run_b(input int v);
    int lat;
    bit got, hold_bad;
    logic [20:0] e;
    e = exp_seg(v, 2, 0);
    for (int i = 0; i < 20 && !rdy_b; i++) tick();
    check("b_rdy_before", {31'b0, rdy_b}, 1);
    in_b = v[4:0];
    val_b = 1'b1;
    tick();
    val_b = 1'b0;
    lat = 0; got = 0; hold_bad = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (seg_b !== prev_b[13:0]) hold_bad = 1;
      tick();
      lat++;
      if (done_b) got = 1;
    end
    check("b_latency", lat, 6);
    check("b_seg_held", {31'b0, hold_bad}, 0);
    check("b_seg", {18'b0, seg_b}, {18'b0, e[13:0]});
    tick();
    check("b_done_one_cycle", {31'b0, done_b}, 0);
    prev_b = e;
  endtask

  initial begin
    int ndone, first, second, cyc, dcount;
    bit pre, hold_bad;
    logic [20:0] e42, e199;

    rst = 1'b0; val_a = 0; in_a = 0; val_b = 0; in_b = 0;
    tick(); tick();
    rst = 1'b1;
    check("rst_seg_a", {11'b0, seg_a}, 32'h1FFFFF);
    check("rst_done_a", {31'b0, done_a}, 0);
    check("rst_rdy_a", {31'b0, rdy_a}, 1);
    check("rst_seg_b", {18'b0, seg_b}, 32'h3FFF);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_a || done_b) dcount++;
    end
    check("idle_no_done", dcount, 0);
    prev_a = '1;
    prev_b = '1;

    run_a(255);
    check("a_255_pattern", {11'b0, seg_a}, {11'b0, 7'b0100100, 7'b0010010, 7'b0010010});
    run_a(0);
    run_a(7);
    run_a(100);
    for (int i = 0; i < 6; i++) run_a(int'($urandom_range(0, 255)));

    // Back-to-back with in_val held high.
    e42 = exp_seg(42, 3, 1);
    e199 = exp_seg(199, 3, 1);
    in_a = 8'd42; val_a = 1'b1;
    ndone = 0; first = -1; second = -1; cyc = 0; hold_bad = 0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      pre = val_a && rdy_a;
      tick();
      cyc++;
      if (pre) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (done_a) begin
        ndone++;
        if (ndone == 1) begin
          check("b2b_seg_42", {11'b0, seg_a}, {11'b0, e42});
          in_a = 8'd199;
        end else begin
          check("b2b_seg_199", {11'b0, seg_a}, {11'b0, e199});
          val_a = 1'b0;
        end
      end else if (ndone == 1 && seg_a !== e42) hold_bad = 1;
    end
    val_a = 1'b0;
    check("b2b_two_done", ndone, 2);
    check("b2b_accept_spacing", second - first, 10);
    check("b2b_hold_42", {31'b0, hold_bad}, 0);
    tick();
    check("b2b_done_low", {31'b0, done_a}, 0);
    prev_a = e199;

    // Reset in the 4th CONV cycle discards the conversion.
    in_a = 8'd200; val_a = 1'b1;
    tick();
    val_a = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_seg", {11'b0, seg_a}, 32'h1FFFFF);
    check("midrst_done", {31'b0, done_a}, 0);
    check("midrst_rdy", {31'b0, rdy_a}, 1);
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done_a) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    prev_a = '1;
    prev_b = '1;
    run_a(9);

    for (int v = 0; v < 32; v++) run_b(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
